// File: rtl/vregfile_pkg.sv
// Shared types and helpers for the vector register file with streaming group writes.
package vregfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ELEMENTS   = 8;

    // Register-group size code as carried on wr_lmul_i.
    typedef enum logic [1:0] {
        LMUL1 = 2'd0,
        LMUL2 = 2'd1,
        LMUL4 = 2'd2,
        LMUL8 = 2'd3
    } lmul_e;

    // Group-write controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // Number of registers in a group for a given size code.
    function automatic logic [3:0] lmul_to_n(input lmul_e lmul);
        logic [3:0] n;
        case (lmul)
            LMUL1:   n = 4'd1;
            LMUL2:   n = 4'd2;
            LMUL4:   n = 4'd4;
            LMUL8:   n = 4'd8;
            default: n = 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vregfile_grp_if.sv
// Group-write stream interface: start handshake, beat stream and completion pulses.
interface vregfile_grp_if #(
    parameter int AW       = 5,
    parameter int VLEN     = 256,
    parameter int ELEMENTS = 8
) ();

    logic                wr_start_i;
    logic                wr_start_ready_o;
    logic [AW-1:0]       wr_base_i;
    logic [1:0]          wr_lmul_i;
    logic                wr_valid_i;
    logic                wr_ready_o;
    logic [VLEN-1:0]     wr_data_i;
    logic [ELEMENTS-1:0] wr_mask_i;
    logic                wr_done_o;
    logic                wr_err_o;

    modport master (
        output wr_start_i, wr_base_i, wr_lmul_i, wr_valid_i, wr_data_i, wr_mask_i,
        input  wr_start_ready_o, wr_ready_o, wr_done_o, wr_err_o
    );

    modport slave (
        input  wr_start_i, wr_base_i, wr_lmul_i, wr_valid_i, wr_data_i, wr_mask_i,
        output wr_start_ready_o, wr_ready_o, wr_done_o, wr_err_o
    );

endinterface

// File: rtl/vregfile_grp_wctl.sv
// Group-write controller: FSM, beat counter, base alignment check and busy scoreboard.
// Drives write enable, address and element mask towards the register array.
module vregfile_grp_wctl
    import vregfile_pkg::*;
#(
    parameter int VREGS    = 32,
    parameter int ELEMENTS = 8,
    parameter int AW       = $clog2(VREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [AW-1:0]       i_base,
    input  logic [1:0]          i_lmul,
    input  logic                i_valid,
    input  logic [ELEMENTS-1:0] i_mask,
    output logic                o_start_ready,
    output logic                o_ready,
    output logic                o_done,
    output logic                o_err,
    output logic [VREGS-1:0]    o_busy,
    output logic                o_wr_en,
    output logic [AW-1:0]       o_wr_addr,
    output logic [ELEMENTS-1:0] o_wr_mask
);

    state_e           r_state;
    logic [AW-1:0]    r_base;
    logic [2:0]       r_last;
    logic [2:0]       r_cnt;
    logic [VREGS-1:0] r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_start_ready;
    logic             r_ready;

    state_e           w_state_nxt;
    logic [AW-1:0]    w_base_nxt;
    logic [2:0]       w_last_nxt;
    logic [2:0]       w_cnt_nxt;
    logic [VREGS-1:0] w_busy_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;

    logic [3:0]       w_n;
    logic [3:0]       w_nm1;
    logic             w_misalign;
    logic             w_beat;
    logic [AW-1:0]    w_wr_addr;

    // Group size decode, alignment check and current beat target.
    always_comb begin
        w_n        = lmul_to_n(lmul_e'(i_lmul));
        w_nm1      = w_n - 4'd1;
        // A group of N registers must start on a multiple of N (N is a power of two).
        w_misalign = |(i_base[2:0] & w_nm1[2:0]);
        w_beat     = i_valid & (r_state == WRITE);
        // Aligned base keeps the low bits free, so this never overflows the register space.
        w_wr_addr  = r_base + AW'(r_cnt);
    end

    // Next-state, counter and scoreboard update.
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (w_misalign) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = WRITE;
                        w_base_nxt  = i_base;
                        w_last_nxt  = w_nm1[2:0];
                        w_cnt_nxt   = 3'd0;
                        // Registers whose address matches the base above the group-offset bits.
                        for (int i = 0; i < VREGS; i++) begin
                            if ((AW'(i) & ~AW'(w_nm1)) == i_base) begin
                                w_busy_nxt[i] = 1'b1;
                            end else begin
                                w_busy_nxt[i] = r_busy[i];
                            end
                        end
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (w_beat) begin
                    w_busy_nxt[w_wr_addr] = 1'b0;
                    if (r_cnt == r_last) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 3'd0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end else begin
                    w_state_nxt = WRITE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Controller state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_base        <= '0;
            r_last        <= 3'd0;
            r_cnt         <= 3'd0;
            r_busy        <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_start_ready <= 1'b1;
            r_ready       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_base        <= w_base_nxt;
            r_last        <= w_last_nxt;
            r_cnt         <= w_cnt_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
            r_start_ready <= (w_state_nxt == IDLE);
            r_ready       <= (w_state_nxt == WRITE);
        end
    end

    assign o_start_ready = r_start_ready;
    assign o_ready       = r_ready;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_busy        = r_busy;
    assign o_wr_en       = w_beat;
    assign o_wr_addr     = w_wr_addr;
    assign o_wr_mask     = i_mask;

endmodule

// File: rtl/vregfile_grp.sv
// Vector register file: NR_RD zero-latency read ports plus one streaming
// LMUL group-write port with per-element write mask and busy scoreboard.
// Optional macro VREGFILE_BYPASS_EN forwards the in-flight beat to readers.
module vregfile_grp
    import vregfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ELEMENTS   = DEF_ELEMENTS,
    parameter int VREGS      = 32,
    parameter int NR_RD      = 3,
    parameter int VLEN       = DATA_WIDTH * ELEMENTS,
    parameter int AW         = $clog2(VREGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NR_RD-1:0][AW-1:0]   rd_addr_i,
    output logic [NR_RD-1:0][VLEN-1:0] rd_data_o,
    output logic [ELEMENTS-1:0]        v0_mask_o,
    vregfile_grp_if.slave              wr_if,
    output logic [VREGS-1:0]           busy_o
);

    logic [VLEN-1:0]     r_regs [VREGS];

    logic                w_wr_en;
    logic [AW-1:0]       w_wr_addr;
    logic [ELEMENTS-1:0] w_wr_mask;
    logic [VLEN-1:0]     w_bitmask;
    logic [VLEN-1:0]     w_merged;

    vregfile_grp_wctl #(
        .VREGS    (VREGS),
        .ELEMENTS (ELEMENTS),
        .AW       (AW)
    ) u_wctl (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (wr_if.wr_start_i),
        .i_base        (wr_if.wr_base_i),
        .i_lmul        (wr_if.wr_lmul_i),
        .i_valid       (wr_if.wr_valid_i),
        .i_mask        (wr_if.wr_mask_i),
        .o_start_ready (wr_if.wr_start_ready_o),
        .o_ready       (wr_if.wr_ready_o),
        .o_done        (wr_if.wr_done_o),
        .o_err         (wr_if.wr_err_o),
        .o_busy        (busy_o),
        .o_wr_en       (w_wr_en),
        .o_wr_addr     (w_wr_addr),
        .o_wr_mask     (w_wr_mask)
    );

    // Element mask expanded to bits, and the old/new merge of the target register.
    always_comb begin
        for (int e = 0; e < ELEMENTS; e++) begin
            w_bitmask[e*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{w_wr_mask[e]}};
        end
        w_merged = (r_regs[w_wr_addr] & ~w_bitmask) | (wr_if.wr_data_i & w_bitmask);
    end

    // Register array: reset clears everything and takes priority over a same-cycle beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < VREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[w_wr_addr] <= w_merged;
        end else begin
            r_regs[w_wr_addr] <= r_regs[w_wr_addr];
        end
    end

`ifdef VREGFILE_BYPASS_EN
    // Combinational reads, forwarding the merged beat when it targets the read address.
    always_comb begin
        for (int p = 0; p < NR_RD; p++) begin
            if (w_wr_en && (rd_addr_i[p] == w_wr_addr)) begin
                rd_data_o[p] = w_merged;
            end else begin
                rd_data_o[p] = r_regs[rd_addr_i[p]];
            end
        end
        for (int e = 0; e < ELEMENTS; e++) begin
            if (w_wr_en && (w_wr_addr == '0)) begin
                v0_mask_o[e] = w_merged[e*DATA_WIDTH];
            end else begin
                v0_mask_o[e] = r_regs[0][e*DATA_WIDTH];
            end
        end
    end
`else
    // Combinational reads straight from the array; a same-cycle write shows next cycle.
    always_comb begin
        for (int p = 0; p < NR_RD; p++) begin
            rd_data_o[p] = r_regs[rd_addr_i[p]];
        end
        for (int e = 0; e < ELEMENTS; e++) begin
            v0_mask_o[e] = r_regs[0][e*DATA_WIDTH];
        end
    end
`endif

endmodule

// File: doc/vregfile_grp.md
Name: vregfile_grp

Overview:
- Parametrised successor vector register file: NR_RD combinational read ports and one streaming group-write port.
- The write port writes an LMUL register group (1/2/4/8 registers) as a valid/ready beat stream, one register per beat.
- Each element has a write mask; masked-off elements keep their old value (mask-undisturbed).
- A per-register busy scoreboard covers in-flight group writes.
- Sits between vector decode/issue (reads, busy check) and the vector execute/load writeback path.

Parameters:
- DATA_WIDTH, 32, element width in bits
- ELEMENTS, 8, elements per register
- VREGS, 32, number of architectural vector registers (power of two, >= 8)
- NR_RD, 3, number of read ports
- VLEN, DATA_WIDTH*ELEMENTS, register width (derived)
- AW, $clog2(VREGS), register address width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- rd_addr_i  in  NR_RD x AW  read addresses
- rd_data_o  out  NR_RD x VLEN  read data, element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- v0_mask_o  out  ELEMENTS  bit 0 of each element of v0, for masking
- wr_start_i  in  1  request to open a group write
- wr_start_ready_o  out  1  group write may start (FSM in IDLE)
- wr_base_i  in  AW  base register of group
- wr_lmul_i  in  2  group size code: 0=1, 1=2, 2=4, 3=8 registers
- wr_valid_i  in  1  beat valid
- wr_ready_o  out  1  beat accepted when valid&ready
- wr_data_i  in  VLEN  beat data
- wr_mask_i  in  ELEMENTS  per-element write enable for the beat
- wr_done_o  out  1  one-cycle pulse after the last beat is written
- wr_err_o  out  1  one-cycle pulse on a rejected start
- busy_o  out  VREGS  scoreboard: register has an open group write

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk. Reset clears all registers to 0, sets FSM to IDLE and busy_o to 0, and clears wr_done_o, wr_err_o and the beat counter. wr_start_ready_o=1 and wr_ready_o=0 after reset.
- Reset mid-group aborts the write. Beats already written stay cleared by the reset, because reset wins over a same-cycle write.
- Reads are combinational from the register array, zero latency. v0 is a normal register, not hardwired to zero. v0_mask_o is the live v0 state.
- FSM states: IDLE, WRITE.
- IDLE:
  - wr_start_ready_o=1, wr_ready_o=0.
  - On wr_start_i: N = 1<<wr_lmul_i.
  - If wr_base_i % N != 0, pulse wr_err_o next cycle and stay in IDLE.
  - Otherwise latch base and N, clear the beat counter, set busy bits for base..base+N-1, and go to WRITE.
- WRITE:
  - wr_start_ready_o=0, wr_ready_o=1. A wr_start_i is ignored with no error.
  - On an accepted beat, register base+cnt, element i, takes wr_data_i element i wherever wr_mask_i[i]=1. The write is visible to reads the next cycle.
  - The busy bit of base+cnt clears on that same edge.
  - cnt then increments; once it reaches N-1 the FSM returns to IDLE and pulses wr_done_o for one cycle.
  - Stalls (wr_valid_i=0) hold all state.
- A beat with an all-zero mask is accepted, advances cnt, and changes no data.
- Counter width is 3 bits, with no wrap beyond N-1. The aligned base guarantees base+cnt < VREGS.
- Read of a register written in the same cycle returns the old value, unless VREGFILE_BYPASS_EN is defined.

Optional Feature:
- Macro: VREGFILE_BYPASS_EN.
- Defined: a read port whose address equals base+cnt during an accepted beat returns the merged value for that cycle. Merged value = new element where the mask is set, old element elsewhere. Applies to v0_mask_o as well.
- Undefined: reads always return the array contents; no bypass muxes are generated.

Decomposition:
- Package vregfile_pkg holds:
  - typedef lmul_e (LMUL1, LMUL2, LMUL4, LMUL8)
  - typedef state_e (IDLE, WRITE)
  - function lmul_to_n
  - constants for the default DATA_WIDTH and ELEMENTS
- Sub-module vregfile_grp_wctl holds the FSM, beat counter, alignment check and busy scoreboard. It outputs the write address, write enable and element mask to the array in the top module.

Test Plan:
- Reset then read: assert rst_n=0 for 2 cycles after filling v3 -> all rd_data_o=0, busy_o=0, wr_start_ready_o=1.
- LMUL=4 group, base=8, 4 beats of 32'h0000_0A0n per element with stalls between beats -> v8..v11 hold the data; busy_o[8..11] clear one per beat; wr_done_o pulses once, one cycle after beat 4.
- Masked write: v5 preset to all 32'hFFFF_FFFF; LMUL=1 beat of zeros with wr_mask_i=8'b0101_0101 -> v5 elements 0,2,4,6 = 0 and odd elements = FFFF_FFFF.
- Misaligned start: wr_start_i with base=6, lmul=2 (N=4) -> wr_err_o pulses, busy_o unchanged, FSM stays IDLE.
- Same-cycle read/write of v2: without the macro the read returns the old value; with VREGFILE_BYPASS_EN it returns the merged value.
- Reset mid-group: LMUL=8 at base=16, assert rst_n=0 after beat 3 -> FSM returns to IDLE, busy_o=0, v16..v18=0, no wr_done_o.
